// File: rtl/pipe_pkg.sv
// Shared widths and control-bit indices for the elastic
// inter-stage pipeline registers.
package pipe_pkg;

  localparam int NB_CTRL_DEF = 8;
  localparam int NB_DATA_DEF = 134;

  localparam int NB_CTRL_IF_ID  = 8;
  localparam int NB_DATA_IF_ID  = 64;
  localparam int NB_CTRL_ID_EX  = 8;
  localparam int NB_DATA_ID_EX  = 134;
  localparam int NB_CTRL_EX_MEM = 8;
  localparam int NB_DATA_EX_MEM = 102;
  localparam int NB_CTRL_MEM_WB = 8;
  localparam int NB_DATA_MEM_WB = 70;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_JUMP       = 5;
  localparam int CTRL_ALU_SRC    = 6;
  localparam int CTRL_HALT       = 7;

  function automatic int cnt_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One elastic slot: main entry plus a skid entry so that
// ready is purely registered.
module pipe_skid_slot #(
  parameter int NB_CTRL = 8,
  parameter int NB_DATA = 134
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [NB_DATA-1:0] o_data
);

  typedef struct packed {
    logic [NB_CTRL-1:0] ctrl;
    logic [NB_DATA-1:0] data;
  } entry_t;

  logic   main_valid;
  logic   skid_valid;
  entry_t main_q;
  entry_t skid_q;
  logic   accept;
  logic   take;

  assign o_ready = !skid_valid;
  assign o_valid = main_valid;
  assign o_ctrl  = main_q.ctrl;
  assign o_data  = main_q.data;
  assign accept  = i_valid & !skid_valid;
  assign take    = main_valid & i_ready;

  always_ff @(negedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (i_flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (take && skid_valid) begin
      main_q     <= skid_q;
      skid_valid <= 1'b0;
    end else if (!main_valid || take) begin
      main_valid <= accept;
      if (accept) main_q <= '{ctrl: i_ctrl, data: i_data};
    end else if (accept) begin
      skid_q     <= '{ctrl: i_ctrl, data: i_data};
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// DEPTH cascaded skid slots with flush, occupancy count
// and bubble masking of the control field.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter  int NB_CTRL = NB_CTRL_DEF,
  parameter  int NB_DATA = NB_DATA_DEF,
  parameter  int DEPTH   = 1,
  localparam int NB_CNT  = cnt_width(DEPTH)
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [NB_DATA-1:0] o_data,
  output logic [NB_CNT-1:0]  o_count
);

  logic [DEPTH:0]     vld;
  logic [DEPTH:0]     rdy;
  logic [NB_CTRL-1:0] ctl [DEPTH+1];
  logic [NB_DATA-1:0] dat [DEPTH+1];
  logic               acc_in;
  logic               take_out;
  logic [NB_CNT-1:0]  cnt;

  assign vld[0]     = i_valid;
  assign ctl[0]     = i_ctrl;
  assign dat[0]     = i_data;
  assign rdy[DEPTH] = i_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    pipe_skid_slot #(
      .NB_CTRL (NB_CTRL),
      .NB_DATA (NB_DATA)
    ) u_slot (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_flush   (i_flush),
      .i_valid   (vld[k]),
      .o_ready   (rdy[k]),
      .i_ctrl    (ctl[k]),
      .i_data    (dat[k]),
      .o_valid   (vld[k+1]),
      .i_ready   (rdy[k+1]),
      .o_ctrl    (ctl[k+1]),
      .o_data    (dat[k+1])
    );
  end

  assign acc_in   = i_valid & rdy[0];
  assign take_out = vld[DEPTH] & i_ready;

  always_ff @(negedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (i_flush) begin
      cnt <= '0;
    end else begin
      case ({acc_in, take_out})
        2'b10:   cnt <= cnt + NB_CNT'(1);
        2'b01:   cnt <= cnt - NB_CNT'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign o_ready = rdy[0];
  assign o_valid = vld[DEPTH];
  assign o_data  = dat[DEPTH];
  assign o_ctrl  = vld[DEPTH] ? ctl[DEPTH] : '0;
  assign o_count = cnt;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and scoreboarded checks of pipe_stage_elastic
// at DEPTH 1, 2 and 3.
module tb_pipe_stage_elastic;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         flush = 1'b0;
  logic         valid = 1'b0;
  logic [7:0]   ctrl = '0;
  logic [133:0] data = '0;
  logic         r1 = 1'b1;
  logic         r2 = 1'b1;
  logic         r3 = 1'b1;

  logic         ov1, or1, ov2, or2, ov3, or3;
  logic [7:0]   oc1, oc2, oc3;
  logic [133:0] od1, od2, od3;
  logic [1:0]   cnt1;
  logic [2:0]   cnt2, cnt3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DEPTH(1)) d1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush),
    .i_valid(valid), .o_ready(or1), .i_ctrl(ctrl),
    .i_data(data), .o_valid(ov1), .i_ready(r1),
    .o_ctrl(oc1), .o_data(od1), .o_count(cnt1)
  );

  pipe_stage_elastic #(.DEPTH(2)) d2 (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush),
    .i_valid(valid), .o_ready(or2), .i_ctrl(ctrl),
    .i_data(data), .o_valid(ov2), .i_ready(r2),
    .o_ctrl(oc2), .o_data(od2), .o_count(cnt2)
  );

  pipe_stage_elastic #(.DEPTH(3)) d3 (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush),
    .i_valid(valid), .o_ready(or3), .i_ctrl(ctrl),
    .i_data(data), .o_valid(ov3), .i_ready(r3),
    .o_ctrl(oc3), .o_data(od3), .o_count(cnt3)
  );

  task automatic chk(input string tag,
                     input logic [141:0] obs,
                     input logic [141:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [7:0] c,
                      input logic [133:0] d);
    valid = v;
    ctrl  = c;
    data  = d;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    valid = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  logic [141:0] q[$];
  logic [141:0] head;
  logic [159:0] rnd;
  logic         acc;
  logic         tak;

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 142'(ov1), 142'(0));
    chk("rst_ready", 142'(or1), 142'(1));
    chk("rst_ctrl", 142'(oc1), 142'(0));
    chk("rst_data", 142'(od1), 142'(0));
    chk("rst_count", 142'(cnt1), 142'(0));
    #1 rst_n = 1'b1;

    // DEPTH=2 stream, two edges of latency
    send(1'b1, 8'hA5, 134'd1);
    tick();
    chk("str_lat", 142'(ov2), 142'(0));
    chk("str_cnt0", 142'(cnt2), 142'(1));
    for (int i = 2; i <= 4; i++) begin
      send(1'b1, 8'hA5, 134'(i));
      tick();
      chk("str_v", 142'(ov2), 142'(1));
      chk("str_d", 142'(od2), 142'(i - 1));
      chk("str_c", 142'(oc2), 142'(8'hA5));
      chk("str_cnt", 142'(cnt2), 142'(2));
    end
    send(1'b0, 8'h00, 134'd0);
    tick();
    chk("str_d4", 142'(od2), 142'(4));
    chk("str_cnt1", 142'(cnt2), 142'(1));
    tick();
    chk("str_end_v", 142'(ov2), 142'(0));
    chk("str_end_c", 142'(oc2), 142'(0));
    chk("str_end_cnt", 142'(cnt2), 142'(0));

    // DEPTH=1 stall with skid absorption
    do_flush();
    r1 = 1'b0;
    send(1'b1, 8'h01, 134'h11);
    tick();
    chk("stl_rdy1", 142'(or1), 142'(1));
    chk("stl_cnt1", 142'(cnt1), 142'(1));
    send(1'b1, 8'h02, 134'h22);
    tick();
    chk("stl_rdy2", 142'(or1), 142'(0));
    chk("stl_cnt2", 142'(cnt1), 142'(2));
    send(1'b1, 8'h03, 134'h33);
    tick();
    chk("stl_held_cnt", 142'(cnt1), 142'(2));
    chk("stl_held_c", 142'(oc1), 142'(8'h01));
    chk("stl_held_d", 142'(od1), 142'(134'h11));
    r1 = 1'b1;
    tick();
    chk("stl_o2_c", 142'(oc1), 142'(8'h02));
    chk("stl_o2_rdy", 142'(or1), 142'(1));
    chk("stl_o2_cnt", 142'(cnt1), 142'(1));
    tick();
    chk("stl_o3_c", 142'(oc1), 142'(8'h03));
    chk("stl_o3_d", 142'(od1), 142'(134'h33));
    chk("stl_o3_cnt", 142'(cnt1), 142'(1));
    send(1'b0, 8'h00, 134'd0);
    tick();
    chk("stl_done_v", 142'(ov1), 142'(0));
    chk("stl_done_cnt", 142'(cnt1), 142'(0));

    // bubble masking over a stale 8'hFF
    send(1'b1, 8'hFF, 134'h5A5A);
    tick();
    chk("bub_live", 142'(oc1), 142'(8'hFF));
    send(1'b0, 8'h00, 134'd0);
    tick();
    chk("bub_v", 142'(ov1), 142'(0));
    chk("bub_c", 142'(oc1), 142'(8'h00));
    chk("bub_d_held", 142'(od1), 142'(134'h5A5A));

    // DEPTH=2 flush with three held entries and an offer
    do_flush();
    r2 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      send(1'b1, 8'(i), 134'(i));
      tick();
    end
    chk("fl_cnt3", 142'(cnt2), 142'(3));
    chk("fl_head", 142'(od2), 142'(1));
    send(1'b1, 8'h77, 134'h99);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    send(1'b0, 8'h00, 134'd0);
    chk("fl_v", 142'(ov2), 142'(0));
    chk("fl_c", 142'(oc2), 142'(0));
    chk("fl_cnt", 142'(cnt2), 142'(0));
    chk("fl_rdy", 142'(or2), 142'(1));
    r2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_gone", 142'(ov2), 142'(0));
    end

    // async reset mid-transfer on DEPTH=3
    r3 = 1'b0;
    send(1'b1, 8'h0C, 134'hC1);
    tick();
    send(1'b1, 8'h0D, 134'hD2);
    tick();
    chk("mr_cnt", 142'(cnt3), 142'(2));
    send(1'b0, 8'h00, 134'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_v", 142'(ov3), 142'(0));
    chk("mr_rdy", 142'(or3), 142'(1));
    chk("mr_cnt0", 142'(cnt3), 142'(0));
    chk("mr_c", 142'(oc3), 142'(0));
    #1 rst_n = 1'b1;
    r3 = 1'b1;
    tick();
    chk("mr_after", 142'(ov3), 142'(0));

    // DEPTH=3 random traffic against a FIFO scoreboard
    for (int n = 0; n < 10000; n++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      send(1'($urandom_range(0, 1)), 8'($urandom), rnd[133:0]);
      r3 = 1'($urandom_range(0, 1));
      acc = valid & or3;
      tak = ov3 & r3;
      if (tak) begin
        if (q.size() == 0) begin
          chk("rnd_dup", 142'(1), 142'(0));
        end else begin
          head = q.pop_front();
          chk("rnd_out", {oc3, od3}, head);
        end
      end
      if (acc) q.push_back({ctrl, data});
      tick();
      chk("rnd_cnt", 142'(cnt3), 142'(q.size()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
